// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM controller
//
// Purpose: FSM state enum, external SRAM bus widths, phase counter width and
//          a helper that picks the first write phase from the byte mask.
// Ports:   none (package).
package sram_ctrl_pkg;

  localparam int SRAM_AW = 18;  // halfword address width at the SRAM pins
  localparam int SRAM_DW = 16;  // SRAM data width
  localparam int PHASE_W = 4;   // phase counter width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  // A write with no enabled lanes in a halfword never visits that phase.
  function automatic state_t write_entry(input logic [3:0] bmask);
    if (|bmask[1:0]) begin
      return WR_LO;
    end else if (|bmask[3:2]) begin
      return WR_HI;
    end else begin
      return DONE;
    end
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - LSU-side request/response bus of the SRAM controller
//
// Purpose: groups the LSU handshake so the controller and requester share one
//          port. Names keep the controller's point of view (i_ in, o_ out).
// Signals: i_req, i_wren, i_addr[31:0], i_bmask[3:0], i_wdata[31:0] (to ctrl)
//          o_rdata[31:0], o_ack, o_stall (from ctrl)
// Modports: master = requester (LSU), slave = controller.
interface sram_ctrl_if;

  logic        i_req;
  logic        i_wren;
  logic [31:0] i_addr;
  logic [3:0]  i_bmask;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ack;
  logic        o_stall;

  modport master (
    output i_req, i_wren, i_addr, i_bmask, i_wdata,
    input  o_rdata, o_ack, o_stall
  );

  modport slave (
    input  i_req, i_wren, i_addr, i_bmask, i_wdata,
    output o_rdata, o_ack, o_stall
  );

endinterface

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - per-phase cycle counter for the SRAM controller
//
// Purpose: counts cycles spent in the current access phase and flags the last
//          one. Cleared whenever the FSM changes state.
// Ports:   i_clk, i_rst_n   clock, async active-low reset
//          i_load           clear counter (state change this edge)
//          i_count          advance counter (inside an access phase)
//          i_limit[3:0]     count value of the final cycle of the phase
//          o_last           counter has reached i_limit
module sram_phase_timer
  import sram_ctrl_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_count,
  input  logic [PHASE_W-1:0] i_limit,
  output logic               o_last
);

  logic [PHASE_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= '0;
    end else if (i_count) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_last = (cnt == i_limit);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - 32-bit LSU to 16-bit asynchronous SRAM controller
//
// Purpose: splits each 32-bit access into a low and a high halfword phase on a
//          16-bit SRAM, with WAIT_CYCLES SRAM cycles per phase (writes add one
//          we_n-high hold cycle). Completion is a one-cycle o_ack.
// Ports:   i_clk, i_rst_n          clock, async active-low reset
//          lsu (slave)             LSU request/response bus
//          o_sram_addr[17:0]       halfword address
//          o_sram_dq_wr[15:0]      write data, o_sram_dq_oe enables the driver
//          i_sram_dq_rd[15:0]      read data from the resolved DQ bus
//          o_sram_ce_n/we_n/oe_n/lb_n/ub_n  active-low SRAM strobes
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  sram_ctrl_if.slave         lsu,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [SRAM_DW-1:0] o_sram_dq_wr,
  output logic               o_sram_dq_oe,
  input  logic [SRAM_DW-1:0] i_sram_dq_rd,
  output logic               o_sram_ce_n,
  output logic               o_sram_we_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_lb_n,
  output logic               o_sram_ub_n
);

  localparam logic [PHASE_W-1:0] RD_LAST = PHASE_W'(WAIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] WR_LAST = PHASE_W'(WAIT_CYCLES);

  state_t             state;
  state_t             state_nx;
  logic [16:0]        addr_q;
  logic [3:0]         bmask_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               last;
  logic               in_phase;
  logic [PHASE_W-1:0] limit;
  logic               accept;

  // Address bits outside [18:2] are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lsu.i_addr[31:19], lsu.i_addr[1:0]};

  assign accept = (state == IDLE) && lsu.i_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      bmask_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= lsu.i_addr[18:2];
      bmask_q <= lsu.i_bmask;
      wdata_q <= lsu.i_wdata;
    end
  end

  // Each halfword is sampled on the last cycle of its phase, when the SRAM
  // output has had the full wait time to settle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
    end else if (last && state == RD_LO) begin
      rdata_q[15:0] <= i_sram_dq_rd;
    end else if (last && state == RD_HI) begin
      rdata_q[31:16] <= i_sram_dq_rd;
    end
  end

  // Kept outside the next-state block so the timer's last flag does not form
  // a combinational loop through it.
  assign in_phase = (state == RD_LO) || (state == RD_HI) ||
                    (state == WR_LO) || (state == WR_HI);
  assign limit    = (state == WR_LO || state == WR_HI) ? WR_LAST : RD_LAST;

  sram_phase_timer u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (state_nx != state),
    .i_count (in_phase),
    .i_limit (limit),
    .o_last  (last)
  );

  always_comb begin
    state_nx     = state;
    o_sram_ce_n  = 1'b1;
    o_sram_we_n  = 1'b1;
    o_sram_oe_n  = 1'b1;
    o_sram_lb_n  = 1'b1;
    o_sram_ub_n  = 1'b1;
    o_sram_dq_oe = 1'b0;
    o_sram_addr  = '0;
    o_sram_dq_wr = '0;
    unique case (state)
      IDLE: begin
        if (lsu.i_req) begin
          state_nx = lsu.i_wren ? write_entry(lsu.i_bmask) : RD_LO;
        end
      end
      RD_LO, RD_HI: begin
        o_sram_ce_n = 1'b0;
        o_sram_oe_n = 1'b0;
        o_sram_lb_n = 1'b0;
        o_sram_ub_n = 1'b0;
        o_sram_addr = {addr_q, state == RD_HI};
        if (last) begin
          state_nx = (state == RD_LO) ? RD_HI : DONE;
        end
      end
      WR_LO: begin
        o_sram_ce_n  = 1'b0;
        o_sram_dq_oe = 1'b1;
        o_sram_we_n  = last;  // released for the final hold cycle
        o_sram_lb_n  = ~bmask_q[0];
        o_sram_ub_n  = ~bmask_q[1];
        o_sram_addr  = {addr_q, 1'b0};
        o_sram_dq_wr = wdata_q[15:0];
        if (last) begin
          state_nx = (|bmask_q[3:2]) ? WR_HI : DONE;
        end
      end
      WR_HI: begin
        o_sram_ce_n  = 1'b0;
        o_sram_dq_oe = 1'b1;
        o_sram_we_n  = last;
        o_sram_lb_n  = ~bmask_q[2];
        o_sram_ub_n  = ~bmask_q[3];
        o_sram_addr  = {addr_q, 1'b1};
        o_sram_dq_wr = wdata_q[31:16];
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign lsu.o_ack   = (state == DONE);
  assign lsu.o_stall = lsu.i_req && (state != DONE);
  assign lsu.o_rdata = rdata_q;

endmodule
